writeback_dma: RTL and testbench

// - AXI4 write-master DMA for the final stage of a TPU job. Started by the control unit's

---
 rtl/writeback_dma.sv | 171 +++++++++++++++++
 tb/tb_writeback_dma.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_dma.sv
// rtl/writeback_dma.sv - AXI4 write-master DMA streaming result-buffer words to DDR in 4 KB-safe INCR bursts
// Optional feature macro: WB_ERR_STATUS_EN (sticky write-response error status outputs).
module writeback_dma #(
    parameter int ADDR_WIDTH     = 10,
    parameter int DATA_WIDTH     = 32,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int MAX_BURST      = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_pulse,
    input  logic [AXI_ADDR_WIDTH-1:0] dest_addr,
    input  logic [ADDR_WIDTH-1:0]     src_addr,
    input  logic [15:0]               length,
    output logic                      done_irq,
    output logic                      busy,
    output logic                      buf_rd_en,
    output logic [ADDR_WIDTH-1:0]     buf_rd_addr,
    input  logic [DATA_WIDTH-1:0]     buf_rd_data,
    output logic [AXI_ADDR_WIDTH-1:0] m_awaddr,
    output logic [7:0]                m_awlen,
    output logic [2:0]                m_awsize,
    output logic [1:0]                m_awburst,
    output logic                      m_awvalid,
    input  logic                      m_awready,
    output logic [DATA_WIDTH-1:0]     m_wdata,
    output logic [DATA_WIDTH/8-1:0]   m_wstrb,
    output logic                      m_wlast,
    output logic                      m_wvalid,
    input  logic                      m_wready,
    input  logic [1:0]                m_bresp,
    input  logic                      m_bvalid,
    output logic                      m_bready
`ifdef WB_ERR_STATUS_EN
    ,
    output logic                      err_sticky,
    output logic [1:0]                err_resp
`endif
);

    localparam int BYTES      = DATA_WIDTH / 8;
    localparam int BYTE_SHIFT = $clog2(BYTES);
    localparam logic [AXI_ADDR_WIDTH-1:0] LOW_MASK = AXI_ADDR_WIDTH'(BYTES - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_AW   = 3'd1;
    localparam logic [2:0] S_W    = 3'd2;
    localparam logic [2:0] S_B    = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]                state;
    logic [AXI_ADDR_WIDTH-1:0] addr;
    logic [15:0]               remaining;
    logic [ADDR_WIDTH-1:0]     rd_addr;
    logic [8:0]                fetch_cnt;
    logic [8:0]                sent_cnt;
    logic [8:0]                beats;
    logic [12:0]               to_4k_beats;
    logic [DATA_WIDTH-1:0]     fifo_mem [2];
    logic                      wr_ptr;
    logic                      rd_ptr;
    logic                      rd_inflight;
    logic [1:0]                fifo_cnt;
    logic                      push;
    logic                      pop;

    // addr and remaining only move on the B handshake, so the burst size is stable from AW through B
    always_comb begin
        to_4k_beats = (13'h1000 - {1'b0, addr[11:0]}) >> BYTE_SHIFT;
        beats       = 9'(MAX_BURST);
        if (to_4k_beats < 13'(beats)) beats = to_4k_beats[8:0];
        if (remaining < 16'(beats)) beats = remaining[8:0];
    end

    assign busy        = (state != S_IDLE);
    assign m_awaddr    = addr;
    assign m_awlen     = 8'(beats - 9'd1);
    assign m_awsize    = 3'(BYTE_SHIFT);
    assign m_awburst   = 2'b01;
    assign m_awvalid   = (state == S_AW);
    assign m_wvalid    = (state == S_W) && (fifo_cnt != 2'd0);
    assign m_wdata     = fifo_mem[rd_ptr];
    assign m_wstrb     = '1;
    assign m_wlast     = m_wvalid && (sent_cnt == beats - 9'd1);
    assign m_bready    = (state == S_B);
    assign buf_rd_addr = rd_addr;
    assign push        = rd_inflight;
    assign pop         = m_wvalid && m_wready;

    // occupancy plus the read still in flight never exceeds the two skid entries
    assign buf_rd_en = ((state == S_AW) || (state == S_W))
                     && ((fifo_cnt + {1'b0, rd_inflight}) < 2'd2)
                     && (fetch_cnt < beats);

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= buf_rd_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            addr        <= '0;
            remaining   <= '0;
            rd_addr     <= '0;
            fetch_cnt   <= '0;
            sent_cnt    <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            fifo_cnt    <= '0;
            rd_inflight <= 1'b0;
            done_irq    <= 1'b0;
        end else begin
            done_irq    <= (state == S_DONE);
            rd_inflight <= buf_rd_en;
            fifo_cnt    <= fifo_cnt + {1'b0, push} - {1'b0, pop};
            if (push) wr_ptr <= ~wr_ptr;
            if (buf_rd_en) begin
                rd_addr   <= rd_addr + ADDR_WIDTH'(1);
                fetch_cnt <= fetch_cnt + 9'd1;
            end
            if (pop) begin
                rd_ptr   <= ~rd_ptr;
                sent_cnt <= sent_cnt + 9'd1;
            end
            case (state)
                S_IDLE: begin
                    if (start_pulse) begin
                        addr      <= dest_addr & ~LOW_MASK;
                        rd_addr   <= src_addr;
                        remaining <= length;
                        fetch_cnt <= '0;
                        sent_cnt  <= '0;
                        state     <= (length == 16'd0) ? S_DONE : S_AW;
                    end
                end
                S_AW: if (m_awready) state <= S_W;
                S_W:  if (pop && m_wlast) state <= S_B;
                S_B: begin
                    if (m_bvalid) begin
                        addr      <= addr + (AXI_ADDR_WIDTH'(beats) << BYTE_SHIFT);
                        remaining <= remaining - 16'(beats);
                        fetch_cnt <= '0;
                        sent_cnt  <= '0;
                        state     <= (remaining == 16'(beats)) ? S_DONE : S_AW;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef WB_ERR_STATUS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err_sticky <= 1'b0;
            err_resp   <= 2'b00;
        end else if ((state == S_IDLE) && start_pulse) begin
            err_sticky <= 1'b0;
            err_resp   <= 2'b00;
        end else if (m_bready && m_bvalid && (m_bresp != 2'b00)) begin
            if (!err_sticky) err_resp <= m_bresp;
            err_sticky <= 1'b1;
        end
    end
`else
    logic bresp_unused;
    assign bresp_unused = ^m_bresp;
`endif

endmodule

// File: tb/tb_writeback_dma.sv
// tb/tb_writeback_dma.sv - randomized self-checking bench for writeback_dma against a burst-splitting reference model
module tb_writeback_dma;

    logic        clk;
    logic        rst;
    logic        start_pulse;
    logic [31:0] dest_addr;
    logic [9:0]  src_addr;
    logic [15:0] length;
    logic        done_irq;
    logic        busy;
    logic        buf_rd_en;
    logic [9:0]  buf_rd_addr;
    logic [31:0] buf_rd_data;
    logic [31:0] m_awaddr;
    logic [7:0]  m_awlen;
    logic [2:0]  m_awsize;
    logic [1:0]  m_awburst;
    logic        m_awvalid;
    logic        m_awready;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_wlast;
    logic        m_wvalid;
    logic        m_wready;
    logic [1:0]  m_bresp;
    logic        m_bvalid;
    logic        m_bready;
`ifdef WB_ERR_STATUS_EN
    logic        err_sticky;
    logic [1:0]  err_resp;
`endif

    writeback_dma #(
        .ADDR_WIDTH(10), .DATA_WIDTH(32), .AXI_ADDR_WIDTH(32), .MAX_BURST(16)
    ) dut (
        .clk(clk), .rst(rst), .start_pulse(start_pulse), .dest_addr(dest_addr),
        .src_addr(src_addr), .length(length), .done_irq(done_irq), .busy(busy),
        .buf_rd_en(buf_rd_en), .buf_rd_addr(buf_rd_addr), .buf_rd_data(buf_rd_data),
        .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready), .m_bresp(m_bresp),
        .m_bvalid(m_bvalid), .m_bready(m_bready)
`ifdef WB_ERR_STATUS_EN
        , .err_sticky(err_sticky), .err_resp(err_resp)
`endif
    );

    typedef struct { logic [31:0] addr; logic [7:0] len; logic [2:0] size; logic [1:0] burst; } aw_rec_t;
    typedef struct { logic [31:0] data; logic [3:0] strb; logic last; } w_rec_t;
    typedef struct { logic [31:0] addr; int beats; } burst_t;

    aw_rec_t     aw_q[$];
    w_rec_t      w_q[$];
    burst_t      exp_bursts[$];
    logic [31:0] buf_mem [1024];

    int   total;
    int   bad;
    int   done_cnt;
    int   valid_cycles;
    int   stable_err;
    int   b_idx;
    int   bad_burst;
    bit   stall_en;
    bit   b_owed;
    bit   b_hs;
    bit   aw_hold;
    bit   w_hold;
    logic [31:0] held_wdata;
    logic        held_wlast;
    logic [31:0] held_awaddr;
    logic [7:0]  held_awlen;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (buf_rd_en) buf_rd_data <= buf_mem[buf_rd_addr];
    end

    // AXI slave: drives readies/B at the falling edge and logs what will handshake at the next rising edge
    always @(negedge clk) begin
        if (rst) begin
            m_awready = 1'b0;
            m_wready  = 1'b0;
            m_bvalid  = 1'b0;
            m_bresp   = 2'b00;
            b_owed    = 1'b0;
            b_hs      = 1'b0;
            aw_hold   = 1'b0;
            w_hold    = 1'b0;
        end else begin
            if (b_hs) begin
                m_bvalid = 1'b0;
                b_owed   = 1'b0;
                b_hs     = 1'b0;
                b_idx++;
            end
            if (w_hold && (!m_wvalid || m_wdata !== held_wdata || m_wlast !== held_wlast)) stable_err++;
            if (aw_hold && (!m_awvalid || m_awaddr !== held_awaddr || m_awlen !== held_awlen)) stable_err++;
            m_awready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
            m_wready  = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
            if (b_owed && !m_bvalid && (!stall_en || $urandom_range(0, 1) == 1)) begin
                m_bvalid = 1'b1;
                m_bresp  = (b_idx == bad_burst) ? 2'b10 : 2'b00;
            end
            if (m_awvalid && m_awready) aw_q.push_back('{m_awaddr, m_awlen, m_awsize, m_awburst});
            aw_hold     = m_awvalid && !m_awready;
            held_awaddr = m_awaddr;
            held_awlen  = m_awlen;
            if (m_wvalid && m_wready) begin
                w_q.push_back('{m_wdata, m_wstrb, m_wlast});
                if (m_wlast) b_owed = 1'b1;
            end
            w_hold     = m_wvalid && !m_wready;
            held_wdata = m_wdata;
            held_wlast = m_wlast;
            if (m_bvalid && m_bready) b_hs = 1'b1;
            if (m_awvalid || m_wvalid) valid_cycles++;
            if (done_irq) done_cnt++;
        end
    end

    // Reference: greedy split into bursts limited by words left, MAX_BURST and the next 4 KB page
    function automatic void model_bursts(input logic [31:0] dest, input int len);
        longint a;
        int     rem;
        a   = longint'(dest) & 64'hFFFF_FFFC;
        rem = len;
        exp_bursts.delete();
        while (rem > 0) begin
            int room;
            int n;
            room = (4096 - int'(a % 4096)) / 4;
            n    = rem;
            if (n > 16) n = 16;
            if (n > room) n = room;
            exp_bursts.push_back('{a[31:0], n});
            a   = (a + longint'(n * 4)) & 64'hFFFF_FFFF;
            rem = rem - n;
        end
    endfunction

    task automatic run_job(input logic [31:0] dest, input logic [9:0] src, input logic [15:0] len,
                           input bit poke, output int cycles, output bit timed_out);
        aw_q.delete();
        w_q.delete();
        done_cnt     = 0;
        valid_cycles = 0;
        stable_err   = 0;
        b_idx        = 0;
        @(negedge clk);
        dest_addr   = dest;
        src_addr    = src;
        length      = len;
        start_pulse = 1'b1;
        @(negedge clk);
        start_pulse = 1'b0;
        dest_addr   = $urandom;
        src_addr    = 10'($urandom);
        length      = 16'($urandom);
        cycles      = 1;
        while (!done_irq && cycles < 4000) begin
            @(negedge clk);
            cycles++;
            start_pulse = (poke && cycles == 3);
        end
        timed_out   = !done_irq;
        start_pulse = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({m_awvalid, m_wvalid, m_bready, buf_rd_en} !== 4'b0000)
            $display("FAIL reset_valids got=%b exp=0000", {m_awvalid, m_wvalid, m_bready, buf_rd_en});
        total++;
        if ({busy, done_irq} !== 2'b00) $display("FAIL reset_busy_done got=%b exp=00", {busy, done_irq});
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_zero_length();
        int cyc;
        bit to;
        stall_en = 1'b0;
        run_job(32'h0000_0100, 10'h5, 16'd0, 1'b0, cyc, to);
        total++; if (to) begin bad++; $display("FAIL zero_timeout got=timeout exp=done"); end
        total++; if (cyc != 2) begin bad++; $display("FAIL zero_latency got=%0d exp=2", cyc); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL zero_done_count got=%0d exp=1", done_cnt); end
        total++; if (valid_cycles != 0) begin bad++; $display("FAIL zero_axi_traffic got=%0d exp=0", valid_cycles); end
    endtask

    task automatic test_single_burst();
        int cyc;
        bit to;
        stall_en = 1'b0;
        run_job(32'h0000_1000, 10'h010, 16'd5, 1'b0, cyc, to);
        total++; if (to) begin bad++; $display("FAIL single_timeout got=timeout exp=done"); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL single_done_count got=%0d exp=1", done_cnt); end
        total++; if (aw_q.size() != 1) begin bad++; $display("FAIL single_aw_count got=%0d exp=1", aw_q.size()); end
        if (aw_q.size() >= 1) begin
            total++;
            if (aw_q[0].addr !== 32'h1000 || aw_q[0].len !== 8'd4 || aw_q[0].size !== 3'd2 || aw_q[0].burst !== 2'b01) begin
                bad++;
                $display("FAIL single_aw got=%h/%0d/%0d/%0d exp=00001000/4/2/1",
                         aw_q[0].addr, aw_q[0].len, aw_q[0].size, aw_q[0].burst);
            end
        end
        total++; if (w_q.size() != 5) begin bad++; $display("FAIL single_beat_count got=%0d exp=5", w_q.size()); end
        for (int i = 0; i < 5; i++) begin
            if (i < w_q.size()) begin
                total++;
                if (w_q[i].data !== buf_mem[16 + i] || w_q[i].strb !== 4'hF || w_q[i].last !== (i == 4)) begin
                    bad++;
                    $display("FAIL single_beat%0d got=%h/%h/%b exp=%h/f/%b",
                             i, w_q[i].data, w_q[i].strb, w_q[i].last, buf_mem[16 + i], i == 4);
                end
            end
        end
    endtask

    task automatic test_burst_split();
        logic [31:0] dests [6] = '{32'h0000_0000, 32'h0000_0FF8, 32'h0000_0FC4, 32'h0000_1FFC, 32'hFFFF_FFF0, 32'h0000_2003};
        int          lens  [6] = '{40, 6, 50, 3, 9, 17};
        int cyc;
        bit to;
        stall_en = 1'b0;
        for (int t = 0; t < 6; t++) begin
            model_bursts(dests[t], lens[t]);
            run_job(dests[t], 10'($urandom), 16'(lens[t]), 1'b0, cyc, to);
            total++; if (to) begin bad++; $display("FAIL split%0d_timeout got=timeout exp=done", t); end
            total++;
            if (aw_q.size() != exp_bursts.size()) begin
                bad++;
                $display("FAIL split%0d_count got=%0d exp=%0d", t, aw_q.size(), exp_bursts.size());
            end
            foreach (exp_bursts[b]) begin
                if (b < aw_q.size()) begin
                    total++;
                    if (aw_q[b].addr !== exp_bursts[b].addr || aw_q[b].len !== 8'(exp_bursts[b].beats - 1)
                        || aw_q[b].size !== 3'd2 || aw_q[b].burst !== 2'b01) begin
                        bad++;
                        $display("FAIL split%0d_burst%0d got=%h/%0d exp=%h/%0d",
                                 t, b, aw_q[b].addr, aw_q[b].len, exp_bursts[b].addr, exp_bursts[b].beats - 1);
                    end
                end
            end
        end
    endtask

    task automatic test_random_stall();
        int cyc;
        bit to;
        logic [31:0] dest;
        logic [9:0]  src;
        int          len;
        int          beat_no;
        stall_en = 1'b1;
        for (int j = 0; j < 6; j++) begin
            dest = $urandom;
            src  = 10'($urandom);
            len  = (j == 0) ? 20 : int'($urandom_range(1, 70));
            model_bursts(dest, len);
            run_job(dest, src, 16'(len), j == 0, cyc, to);
            total++; if (to) begin bad++; $display("FAIL rand%0d_timeout got=timeout exp=done", j); end
            total++; if (done_cnt != 1) begin bad++; $display("FAIL rand%0d_done_count got=%0d exp=1", j, done_cnt); end
            total++; if (stable_err != 0) begin bad++; $display("FAIL rand%0d_stall_stability got=%0d exp=0", j, stable_err); end
            total++;
            if (aw_q.size() != exp_bursts.size()) begin
                bad++;
                $display("FAIL rand%0d_burst_count got=%0d exp=%0d", j, aw_q.size(), exp_bursts.size());
            end
            total++; if (w_q.size() != len) begin bad++; $display("FAIL rand%0d_beat_count got=%0d exp=%0d", j, w_q.size(), len); end
            beat_no = 0;
            foreach (exp_bursts[b]) begin
                for (int k = 0; k < exp_bursts[b].beats; k++) begin
                    if (beat_no < w_q.size()) begin
                        total++;
                        if (w_q[beat_no].data !== buf_mem[(int'(src) + beat_no) % 1024]
                            || w_q[beat_no].last !== (k == exp_bursts[b].beats - 1)) begin
                            bad++;
                            $display("FAIL rand%0d_beat%0d got=%h/%b exp=%h/%b", j, beat_no, w_q[beat_no].data,
                                     w_q[beat_no].last, buf_mem[(int'(src) + beat_no) % 1024], k == exp_bursts[b].beats - 1);
                        end
                    end
                    beat_no++;
                end
            end
        end
        stall_en = 1'b0;
    endtask

    task automatic test_reset_mid_w();
        int n;
        int cyc;
        bit to;
        stall_en = 1'b0;
        @(negedge clk);
        dest_addr   = 32'h0000_3000;
        src_addr    = 10'h2A0;
        length      = 16'd16;
        start_pulse = 1'b1;
        @(negedge clk);
        start_pulse = 1'b0;
        n = 0;
        while (!m_wvalid && n < 50) begin
            @(negedge clk);
            n++;
        end
        total++; if (!m_wvalid) begin bad++; $display("FAIL rstmid_reach_w got=0 exp=1"); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({busy, done_irq, m_awvalid, m_wvalid, m_bready, buf_rd_en} !== 6'b0) begin
            bad++;
            $display("FAIL rstmid_outputs got=%b exp=000000", {busy, done_irq, m_awvalid, m_wvalid, m_bready, buf_rd_en});
        end
        @(negedge clk);
        rst      = 1'b0;
        done_cnt = 0;
        repeat (5) @(negedge clk);
        total++; if (done_cnt != 0) begin bad++; $display("FAIL rstmid_spurious_done got=%0d exp=0", done_cnt); end
        run_job(32'h0000_3000, 10'h3FE, 16'd3, 1'b0, cyc, to);
        total++; if (to) begin bad++; $display("FAIL rstmid_timeout got=timeout exp=done"); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL rstmid_done_count got=%0d exp=1", done_cnt); end
        total++;
        if (aw_q.size() != 1 || w_q.size() != 3) begin
            bad++;
            $display("FAIL rstmid_shape got=%0d/%0d exp=1/3", aw_q.size(), w_q.size());
        end
        if (aw_q.size() >= 1) begin
            total++;
            if (aw_q[0].addr !== 32'h3000 || aw_q[0].len !== 8'd2) begin
                bad++;
                $display("FAIL rstmid_aw got=%h/%0d exp=00003000/2", aw_q[0].addr, aw_q[0].len);
            end
        end
        for (int i = 0; i < 3; i++) begin
            if (i < w_q.size()) begin
                total++;
                if (w_q[i].data !== buf_mem[(1022 + i) % 1024]) begin
                    bad++;
                    $display("FAIL rstmid_beat%0d got=%h exp=%h", i, w_q[i].data, buf_mem[(1022 + i) % 1024]);
                end
            end
        end
    endtask

`ifdef WB_ERR_STATUS_EN
    task automatic test_err_status();
        int cyc;
        bit to;
        stall_en  = 1'b0;
        bad_burst = 1;
        run_job(32'h0000_0000, 10'h100, 16'd40, 1'b0, cyc, to);
        bad_burst = -1;
        total++; if (to || done_cnt != 1) begin bad++; $display("FAIL err_done got=%0d exp=1", done_cnt); end
        total++; if (aw_q.size() != 3) begin bad++; $display("FAIL err_bursts got=%0d exp=3", aw_q.size()); end
        total++; if (err_sticky !== 1'b1) begin bad++; $display("FAIL err_sticky_set got=%b exp=1", err_sticky); end
        total++; if (err_resp !== 2'b10) begin bad++; $display("FAIL err_resp_capture got=%b exp=10", err_resp); end
        run_job(32'h0000_0500, 10'h0, 16'd2, 1'b0, cyc, to);
        total++;
        if ({err_sticky, err_resp} !== 3'b000) begin
            bad++;
            $display("FAIL err_clear_on_start got=%b exp=000", {err_sticky, err_resp});
        end
    endtask
`endif

    initial begin
        total       = 0;
        bad         = 0;
        rst         = 1'b1;
        start_pulse = 1'b0;
        dest_addr   = '0;
        src_addr    = '0;
        length      = '0;
        stall_en    = 1'b0;
        bad_burst   = -1;
        b_idx       = 0;
        done_cnt    = 0;
        foreach (buf_mem[i]) buf_mem[i] = $urandom;
        test_reset();
        test_zero_length();
        test_single_burst();
        test_burst_split();
        test_random_stall();
        test_reset_mid_w();
`ifdef WB_ERR_STATUS_EN
        test_err_status();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
